// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer: owns the PC, runs a req/ack handshake to instruction memory,
// and applies freeze stalls and branch redirects, including squashing an in-flight fetch.
module if_fetch_ctrl #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               Branch_taken,
  input  logic [ADDR_W-1:0]  BranchAddr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  PC,
  output logic [INSTR_W-1:0] Instruction,
  output logic               if_valid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_DROP
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   drop_addr_q, drop_addr_d;
  logic [INSTR_W-1:0]  buf_q, buf_d;
  logic [ADDR_W-1:0]   pc_out_q, pc_out_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic                valid_q, valid_d;

  logic [ADDR_W-1:0]   pc_inc;
  logic [ADDR_W-1:0]   br_tgt;

  assign pc_inc = pc_q + PC_STEP;
  assign br_tgt = BranchAddr & ~ADDR_W'(3);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      drop_addr_q <= RESET_PC;
      buf_q       <= '0;
      pc_out_q    <= '0;
      instr_q     <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      buf_q       <= buf_d;
      pc_out_q    <= pc_out_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    buf_d       = buf_q;
    pc_out_d    = pc_out_q;
    instr_d     = instr_q;
    valid_d     = 1'b0;

    if (Branch_taken) begin
      pc_d = br_tgt;
      unique case (state_q)
        S_REQ: begin
          // An unacknowledged fetch must finish at its original address before retargeting.
          if (imem_ack) begin
            state_d = S_REQ;
          end else begin
            state_d     = S_DROP;
            drop_addr_d = pc_q;
          end
        end
        S_DROP:  state_d = S_DROP;
        default: state_d = S_REQ;
      endcase
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ: begin
          if (imem_ack) begin
            pc_d = pc_inc;
            if (freeze) begin
              buf_d   = imem_rdata;
              state_d = S_HOLD;
            end else begin
              instr_d  = imem_rdata;
              pc_out_d = pc_inc;
              valid_d  = 1'b1;
            end
          end
        end
        S_HOLD: begin
          // pc_q has already advanced past the buffered word, so it is the PC to present.
          if (!freeze) begin
            instr_d  = buf_q;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
            state_d  = S_REQ;
          end
        end
        S_DROP: begin
          if (imem_ack) begin
            state_d = S_REQ;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign imem_req    = (state_q == S_REQ) || (state_q == S_DROP);
  assign imem_addr   = (state_q == S_DROP) ? drop_addr_q : pc_q;
  assign PC          = pc_out_q;
  assign Instruction = instr_q;
  assign if_valid    = valid_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: a latency-programmable memory responder plus an instruction-stream
// scoreboard (next expected fetch address, redirected by branches, reset to RESET_PC).
module tb_if_fetch_ctrl;

  localparam int unsigned AW = 32;
  localparam int unsigned IW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          freeze;
  logic          Branch_taken;
  logic [AW-1:0] BranchAddr;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [IW-1:0] imem_rdata;
  logic [AW-1:0] PC;
  logic [IW-1:0] Instruction;
  logic          if_valid;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // memory responder state
  int unsigned lat_min, lat_max, mem_lat;
  bit          mem_busy, stray_en, force_ack;

  // scoreboard state
  logic [AW-1:0] exp_next, last_pc;
  logic [IW-1:0] last_instr;
  int unsigned   idle, n_dlv;

  // inputs as presented at the most recent edge
  logic          fz_pre, br_pre, ack_pre, req_pre, rst_pre;
  logic [AW-1:0] ba_pre, addr_pre;

  always #5 clk = ~clk;

  if_fetch_ctrl #(
    .ADDR_W  (AW),
    .INSTR_W (IW),
    .RESET_PC(32'h0000_0000),
    .PC_STEP (32'd4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .freeze      (freeze),
    .Branch_taken(Branch_taken),
    .BranchAddr  (BranchAddr),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .PC          (PC),
    .Instruction (Instruction),
    .if_valid    (if_valid)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic monitor();
    logic [AW-1:0] nxt_pc;
    if (!rst_pre) begin
      check_eq("rst_if_valid", if_valid, 32'd0);
      check_eq("rst_pc", PC, 32'd0);
      check_eq("rst_instr", Instruction, 32'd0);
      check_eq("rst_imem_req", imem_req, 32'd0);
      check_eq("rst_imem_addr", imem_addr, 32'd0);
      exp_next   = '0;
      last_pc    = '0;
      last_instr = '0;
      idle       = 0;
    end else begin
      if (br_pre || fz_pre) check_eq("no_valid_br_fz", if_valid, 32'd0);
      if (br_pre) begin
        exp_next = ba_pre & ~32'd3;
      end else if (if_valid) begin
        nxt_pc = exp_next + 32'd4;
        check_eq("dlv_pc", PC, nxt_pc);
        check_eq("dlv_instr", Instruction, exp_next);
        last_pc    = nxt_pc;
        last_instr = exp_next;
        exp_next   = nxt_pc;
        n_dlv++;
      end
      if (!if_valid) begin
        check_eq("keep_pc", PC, last_pc);
        check_eq("keep_instr", Instruction, last_instr);
      end
      if (req_pre && !ack_pre) begin
        check_eq("req_held", imem_req, 32'd1);
        check_eq("addr_held", imem_addr, addr_pre);
      end
      if (if_valid) idle = 0;
      else          idle++;
      if (idle > 64) begin
        check_eq("stall_bound", idle, 32'd0);
        idle = 0;
      end
    end
  endtask

  // One clock: memory answers the current request, the edge happens, the scoreboard runs.
  task automatic tick();
    if (imem_req === 1'b1) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_lat  = $urandom_range(lat_max, lat_min);
      end
      if (mem_lat == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = imem_addr;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        mem_lat--;
      end
    end else begin
      imem_ack   = force_ack || (stray_en && ($urandom_range(3, 0) == 0));
      imem_rdata = $urandom;
    end
    force_ack = 1'b0;
    fz_pre   = freeze;
    br_pre   = Branch_taken;
    ba_pre   = BranchAddr;
    ack_pre  = imem_ack;
    req_pre  = imem_req;
    addr_pre = imem_addr;
    rst_pre  = rst;
    @(posedge clk);
    #1;
    Branch_taken = 1'b0;
    if (!rst_pre || (req_pre && ack_pre)) mem_busy = 1'b0;
    monitor();
  endtask

  task automatic set_lat(input int unsigned lo, input int unsigned hi);
    lat_min = lo;
    lat_max = hi;
  endtask

  initial begin
    rst = 1'b0; freeze = 1'b0; Branch_taken = 1'b0; BranchAddr = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    mem_busy = 1'b0; mem_lat = 0; stray_en = 1'b0; force_ack = 1'b0;
    exp_next = '0; last_pc = '0; last_instr = '0; idle = 0; n_dlv = 0;
    set_lat(0, 0);

    // reset then sequential fetch with ack tied high
    tick(); tick();
    rst = 1'b1;
    tick();
    check_eq("t1_req_after_idle", imem_req, 32'd1);
    check_eq("t1_addr0", imem_addr, 32'h0);
    check_eq("t1_no_valid_edge1", if_valid, 32'd0);
    for (int unsigned k = 1; k <= 3; k++) begin
      tick();
      check_eq("t1_valid", if_valid, 32'd1);
      check_eq("t1_pc", PC, 32'(4 * k));
      check_eq("t1_addr", imem_addr, 32'(4 * k));
    end

    // ack after a 3-cycle hold
    set_lat(2, 2);
    for (int unsigned k = 0; k < 2; k++) begin
      for (int unsigned j = 0; j < 2; j++) begin
        tick();
        check_eq("t2_wait_valid", if_valid, 32'd0);
        check_eq("t2_addr_stable", imem_addr, 32'(12 + 4 * k));
      end
      tick();
      check_eq("t2_valid", if_valid, 32'd1);
      check_eq("t2_pc", PC, 32'(16 + 4 * k));
    end

    // freeze for 4 cycles arriving together with an ack
    set_lat(0, 0);
    freeze = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      tick();
      check_eq("t3_fz_valid", if_valid, 32'd0);
      check_eq("t3_fz_req", imem_req, 32'd0);
    end
    freeze = 1'b0;
    tick();
    check_eq("t3_release_valid", if_valid, 32'd1);
    check_eq("t3_release_pc", PC, 32'd24);
    check_eq("t3_release_instr", Instruction, 32'd20);
    tick();
    check_eq("t3_next_pc", PC, 32'd28);

    // branch squashing an outstanding fetch at 0x10
    Branch_taken = 1'b1; BranchAddr = 32'h10;
    tick();
    check_eq("t4_addr_10", imem_addr, 32'h10);
    set_lat(2, 2);
    tick();
    Branch_taken = 1'b1; BranchAddr = 32'h40;
    tick();
    check_eq("t4_drop_req", imem_req, 32'd1);
    check_eq("t4_drop_addr", imem_addr, 32'h10);
    set_lat(0, 0);
    tick();
    check_eq("t4_addr_40", imem_addr, 32'h40);
    check_eq("t4_no_valid", if_valid, 32'd0);
    tick();
    check_eq("t4_valid", if_valid, 32'd1);
    check_eq("t4_pc", PC, 32'h44);

    // branch beats freeze; target alignment
    Branch_taken = 1'b1; BranchAddr = 32'h23; freeze = 1'b1;
    tick();
    check_eq("t5_addr_20", imem_addr, 32'h20);
    check_eq("t5_req", imem_req, 32'd1);
    freeze = 1'b0;
    tick();
    check_eq("t5_pc", PC, 32'h24);

    // address wrap
    Branch_taken = 1'b1; BranchAddr = 32'hFFFF_FFFC;
    tick();
    check_eq("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
    tick();
    check_eq("t6_wrap_pc", PC, 32'h0);
    check_eq("t6_wrap_addr", imem_addr, 32'h0);

    // reset mid-fetch, then a stale ack while idle
    set_lat(3, 3);
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1; force_ack = 1'b1;
    set_lat(0, 0);
    tick();
    check_eq("t6_stale_valid", if_valid, 32'd0);
    check_eq("t6_stale_instr", Instruction, 32'd0);
    check_eq("t6_restart_addr", imem_addr, 32'h0);
    tick();
    check_eq("t6_restart_pc", PC, 32'h4);

    // randomized traffic
    set_lat(0, 3);
    stray_en = 1'b1;
    n_dlv = 0;
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(199, 0) != 0);
      freeze = ($urandom_range(4, 0) == 0);
      if ($urandom_range(15, 0) == 0) begin
        Branch_taken = 1'b1;
        BranchAddr   = $urandom;
      end
      tick();
    end
    check_eq("rand_progress", (n_dlv > 300) ? 32'd1 : 32'd0, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
